// File: rtl/ifu_pkg.sv
// Shared types and defaults for the instruction fetch unit.
package ifu_pkg;
   localparam int unsigned         IFU_XLEN     = 32;
   localparam logic [IFU_XLEN-1:0] IFU_RESET_PC = 32'h8000_0000;

   typedef struct packed {
      logic [IFU_XLEN-1:0] pc;
      logic [IFU_XLEN-1:0] instr;
   } fetch_entry_t;
endpackage

// File: rtl/ifu_fifo.sv
// Show-ahead synchronous FIFO with flush, async active-low reset and occupancy count.
import ifu_pkg::*;

module ifu_fifo #(
   parameter int W     = 2 * IFU_XLEN,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          push,
   input  logic [W-1:0]  din,
   input  logic          pop,
   output logic [W-1:0]  dout,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);
   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr, rd_ptr;
   logic         do_push, do_pop;

   // Extra pointer MSB tells full (MSBs differ) from empty (MSBs equal).
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty   = (wr_ptr == rd_ptr);
   assign count   = wr_ptr - rd_ptr;
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
   end
endmodule

// File: rtl/ifu_prefetch.sv
// Prefetching fetch unit: credit-limited request issue, in-order response buffering,
// redirect flush with stale-response dropping. Optional counters under IFU_PERF_CNT_EN.
import ifu_pkg::*;

module ifu_prefetch #(
   parameter int              XLEN      = IFU_XLEN,
   parameter logic [XLEN-1:0] RESET_PC  = XLEN'(IFU_RESET_PC),
   parameter int              DEPTH     = 4,
   parameter int              MAX_OUTST = 2
) (
   input  logic            clk,
   input  logic            rst,
   output logic            req_valid,
   input  logic            req_ready,
   output logic [XLEN-1:0] req_addr,
   input  logic            rsp_valid,
   input  logic [XLEN-1:0] rsp_data,
   output logic            ifu_valid,
   input  logic            idu_ready,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] instr,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_target
`ifdef IFU_PERF_CNT_EN
   ,
   output logic [31:0]     perf_fetch,
   output logic [31:0]     perf_flush,
   output logic [31:0]     perf_drop
`endif
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int OW = $clog2(MAX_OUTST + 1);

   logic [XLEN-1:0]   fetch_pc, resp_pc, target;
   logic [OW-1:0]     outst, drop, outst_nxt;
   logic              acc, push, pop;
   logic              fifo_full, fifo_empty;
   logic [CW-1:0]     fifo_count;
   logic [2*XLEN-1:0] head;

   assign target = {branch_target[XLEN-1:2], 2'b00};

   // Credits cover both buffered entries and requests still in flight.
   assign req_valid = rst && !branch_taken
                      && ((32'(fifo_count) + 32'(outst)) < 32'(DEPTH))
                      && (32'(outst) < 32'(MAX_OUTST));
   assign req_addr  = fetch_pc;
   assign acc       = req_valid && req_ready;
   assign outst_nxt = outst + OW'(acc) - OW'(rsp_valid);

   assign push      = rsp_valid && (drop == '0) && !branch_taken;
   assign pop       = ifu_valid && idu_ready && !branch_taken;
   assign ifu_valid = !fifo_empty;
   assign pc        = fifo_empty ? '0 : head[2*XLEN-1:XLEN];
   assign instr     = fifo_empty ? '0 : head[XLEN-1:0];

   ifu_fifo #(.W(2*XLEN), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (branch_taken),
      .push  (push),
      .din   ({resp_pc, rsp_data}),
      .pop   (pop),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc <= RESET_PC;
         resp_pc  <= RESET_PC;
         outst    <= '0;
         drop     <= '0;
      end else if (branch_taken) begin
         // Everything still in flight after this edge belongs to the old path.
         fetch_pc <= target;
         resp_pc  <= target;
         outst    <= outst_nxt;
         drop     <= outst_nxt;
      end else begin
         outst <= outst_nxt;
         if (acc) fetch_pc <= fetch_pc + XLEN'(4);
         if (rsp_valid) begin
            if (drop != '0) drop    <= drop - OW'(1);
            else            resp_pc <= resp_pc + XLEN'(4);
         end
      end
   end

   assert property (@(posedge clk) disable iff (!rst) !(push && fifo_full && !pop));

`ifdef IFU_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_fetch <= '0;
         perf_flush <= '0;
         perf_drop  <= '0;
      end else begin
         if (pop)          perf_fetch <= perf_fetch + 32'd1;
         if (branch_taken) perf_flush <= perf_flush + 32'd1;
         if (rsp_valid && ((drop != '0) || branch_taken)) perf_drop <= perf_drop + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_ifu_prefetch.sv
// Scoreboard bench for ifu_prefetch with a variable-latency in-order memory model.
module tb_ifu_prefetch;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid, req_ready;
   logic [31:0] req_addr;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        ifu_valid, idu_ready;
   logic [31:0] pc, instr;
   logic        branch_taken;
   logic [31:0] branch_target;
`ifdef IFU_PERF_CNT_EN
   logic [31:0] perf_fetch, perf_flush, perf_drop;
`endif

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int lat      = 1;

   typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
   typedef struct { logic [31:0] addr; int due; } mreq_t;
   exp_t  sb[$];
   mreq_t mq[$];

   ifu_prefetch #(.XLEN(32), .RESET_PC(32'h8000_0000), .DEPTH(4), .MAX_OUTST(2)) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_addr      (req_addr),
      .rsp_valid     (rsp_valid),
      .rsp_data      (rsp_data),
      .ifu_valid     (ifu_valid),
      .idu_ready     (idu_ready),
      .pc            (pc),
      .instr         (instr),
      .branch_taken  (branch_taken),
      .branch_target (branch_target)
`ifdef IFU_PERF_CNT_EN
      ,
      .perf_fetch    (perf_fetch),
      .perf_flush    (perf_flush),
      .perf_drop     (perf_drop)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hDEAD_BEEF;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string tag);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ifu_valid && n < 50);
      chk(tag, 32'(ifu_valid), 32'd1);
   endtask

   // Memory: returns responses in order, each no earlier than its due cycle.
   initial begin
      rsp_valid = 1'b0;
      rsp_data  = '0;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (rst && mq.size() > 0 && mq[0].due <= cyc) begin
            rsp_valid = 1'b1;
            rsp_data  = mem_word(mq[0].addr);
         end else begin
            rsp_valid = 1'b0;
            rsp_data  = '0;
         end
      end
   end

   // Reference model: every accepted request becomes an expected entry; a redirect discards them.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst) begin
         if (branch_taken) begin
            chk("redir_req_valid", 32'(req_valid), 32'd0);
            sb.delete();
         end else if (ifu_valid && idu_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_pop_pc", pc, 32'hxxxx_xxxx);
            end else begin
               e = sb.pop_front();
               chk("pop_pc", pc, e.pc);
               chk("pop_instr", instr, e.instr);
            end
         end
         if (rsp_valid && mq.size() > 0) void'(mq.pop_front());
         if (req_valid && req_ready) begin
            sb.push_back('{req_addr, mem_word(req_addr)});
            mq.push_back('{req_addr, cyc + lat});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      logic [31:0] a0;
      int n;
      req_ready     = 1'b1;
      idu_ready     = 1'b1;
      branch_taken  = 1'b0;
      branch_target = '0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_req_valid", 32'(req_valid), 32'd0);
      chk("rst_ifu_valid", 32'(ifu_valid), 32'd0);
      chk("rst_pc", pc, 32'd0);
      chk("rst_instr", instr, 32'd0);
`ifdef IFU_PERF_CNT_EN
      chk("rst_perf_fetch", perf_fetch, 32'd0);
      chk("rst_perf_flush", perf_flush, 32'd0);
      chk("rst_perf_drop", perf_drop, 32'd0);
`endif

      // Steady stream, first valid two cycles after release
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("first_req_addr", req_addr, 32'h8000_0000);
      chk("first_req_valid", 32'(req_valid), 32'd1);
      chk("lat_c0_valid", 32'(ifu_valid), 32'd0);
      @(negedge clk);
      chk("lat_c1_valid", 32'(ifu_valid), 32'd0);
      @(negedge clk);
      chk("lat_c2_valid", 32'(ifu_valid), 32'd1);
      chk("first_pc", pc, 32'h8000_0000);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("stream_valid", 32'(ifu_valid), 32'd1);
      end

      // IDU stall: FIFO fills, issue stops, then drains in order
      tick();
      rst = 1'b0;
      mq.delete();
      sb.delete();
      idu_ready = 1'b0;
      tick();
      rst = 1'b1;
      repeat (10) @(negedge clk);
      chk("full_req_valid", 32'(req_valid), 32'd0);
      chk("full_ifu_valid", 32'(ifu_valid), 32'd1);
      tick();
      idu_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("drain_pc", pc, 32'h8000_0000 + 32'(4 * i));
      end

      // Redirect with two requests in flight
      lat = 2;
      n = 0;
      do begin
         tick();
         #1;
         n++;
      end while (mq.size() != 2 && n < 50);
      chk("two_inflight", 32'(mq.size()), 32'd2);
      branch_taken  = 1'b1;
      branch_target = 32'h8000_0101;
      tick();
      branch_taken = 1'b0;
      wait_valid("redir_valid");
      chk("redir_pc", pc, 32'h8000_0100);

      // Redirect coinciding with a pop and a response arrival
      lat = 1;
      repeat (10) tick();
      n = 0;
      do begin
         tick();
         #1;
         n++;
      end while (!(ifu_valid && rsp_valid) && n < 50);
      chk("pop_rsp_coincide", 32'(ifu_valid && rsp_valid), 32'd1);
      branch_taken  = 1'b1;
      branch_target = 32'h8000_0200;
      tick();
      branch_taken = 1'b0;
      @(negedge clk);
      chk("flush_empty", 32'(ifu_valid), 32'd0);
      @(negedge clk);
      chk("redir_lat1_valid", 32'(ifu_valid), 32'd0);
      @(negedge clk);
      chk("redir_lat2_valid", 32'(ifu_valid), 32'd1);
      chk("redir2_pc", pc, 32'h8000_0200);

      // Memory back-pressure: request holds stable, then is accepted once
      tick();
      req_ready = 1'b0;
      @(negedge clk);
      a0 = req_addr;
      for (int i = 0; i < 5; i++) begin
         chk("stall_req_valid", 32'(req_valid), 32'd1);
         chk("stall_req_addr", req_addr, a0);
         @(negedge clk);
      end
      tick();
      req_ready = 1'b1;
      @(negedge clk);
      chk("stall_accept_addr", req_addr, a0);
      @(negedge clk);
      chk("after_accept_addr", req_addr, a0 + 32'd4);
      repeat (6) tick();

      // Asynchronous reset with two requests in flight
      lat = 2;
      n = 0;
      do begin
         tick();
         #1;
         n++;
      end while (mq.size() != 2 && n < 50);
      chk("two_inflight_rst", 32'(mq.size()), 32'd2);
      #1;
      rst = 1'b0;
      mq.delete();
      sb.delete();
      #1;
      chk("arst_req_valid", 32'(req_valid), 32'd0);
      chk("arst_ifu_valid", 32'(ifu_valid), 32'd0);
      chk("arst_pc", pc, 32'd0);
      chk("arst_instr", instr, 32'd0);
`ifdef IFU_PERF_CNT_EN
      chk("arst_perf_fetch", perf_fetch, 32'd0);
      chk("arst_perf_flush", perf_flush, 32'd0);
      chk("arst_perf_drop", perf_drop, 32'd0);
`endif
      lat = 1;
      repeat (2) tick();
      rst = 1'b1;
      @(negedge clk);
      chk("restart_addr", req_addr, 32'h8000_0000);
      wait_valid("restart_valid");
      chk("restart_pc", pc, 32'h8000_0000);
      repeat (10) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
